// File: rtl/gpio_pkg.sv
// gpio_pkg: shared register offsets, parameter defaults and register-select decode
// for the GPIO controller.
package gpio_pkg;

    localparam int GPIO_WIDTH_DEFAULT       = 32;
    localparam int GPIO_SYNC_STAGES_DEFAULT = 2;

    localparam logic [4:0] OFF_OUT      = 5'h00;
    localparam logic [4:0] OFF_DIR      = 5'h04;
    localparam logic [4:0] OFF_IN       = 5'h08;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h0C;
    localparam logic [4:0] OFF_IRQ_STAT = 5'h10;

    typedef enum logic [2:0] {
        SEL_OUT,
        SEL_DIR,
        SEL_IN,
        SEL_IRQ_EN,
        SEL_IRQ_STAT,
        SEL_NONE
    } reg_sel_e;

    // Byte-offset bits [1:0] never reach this decoder; only the word index matters.
    function automatic reg_sel_e decode_sel(input logic [2:0] word_addr);
        reg_sel_e sel;
        case ({word_addr, 2'b00})
            OFF_OUT:      sel = SEL_OUT;
            OFF_DIR:      sel = SEL_DIR;
            OFF_IN:       sel = SEL_IN;
            OFF_IRQ_EN:   sel = SEL_IRQ_EN;
            OFF_IRQ_STAT: sel = SEL_IRQ_STAT;
            default:      sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: WIDTH-wide, SYNC_STAGES-deep flop chain bringing asynchronous pin
// levels into the clk domain.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with registered pin drive and synchronized inputs.
// Define GPIO_IRQ_EN to build the rising-edge interrupt logic (IRQ_EN, IRQ_STAT, irq).
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_en,
    input  logic             mem_we,
    input  logic [4:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    inout  wire  [WIDTH-1:0] gpio,
    output logic             irq
);

    reg_sel_e         sel;
    logic             wr_en;
    logic             rd_en;
    logic             addr_unused;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] rd_val;
`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] rise;
    logic             irq_q, irq_d;
`endif

    assign sel         = decode_sel(addr[4:2]);
    assign addr_unused = ^addr[1:0];
    assign wr_en       = mem_en & mem_we;
    assign rd_en       = mem_en & ~mem_we;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .data_i (gpio),
        .data_o (in_sync)
    );

    // Pads are driven straight from flops so no logic sits between register and pin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_en && sel == SEL_OUT) out_d = wdata;
        if (wr_en && sel == SEL_DIR) dir_d = wdata;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_OUT:      rd_val = out_q;
            SEL_DIR:      rd_val = dir_q;
            SEL_IN:       rd_val = in_sync;
`ifdef GPIO_IRQ_EN
            SEL_IRQ_EN:   rd_val = en_q;
            SEL_IRQ_STAT: rd_val = stat_q;
`endif
            default:      rd_val = '0;
        endcase
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifdef GPIO_IRQ_EN
    assign rise = in_sync & ~hist_q;

    // The edge is OR-ed in after the W1C mask so a coincident set beats the clear.
    always_comb begin
        en_d   = en_q;
        stat_d = stat_q;
        if (wr_en && sel == SEL_IRQ_EN)   en_d   = wdata;
        if (wr_en && sel == SEL_IRQ_STAT) stat_d = stat_q & ~wdata;
        stat_d = stat_d | rise;
        irq_d  = |(stat_q & en_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q   <= '0;
            stat_q <= '0;
            hist_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            stat_q <= stat_d;
            hist_q <= in_sync;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: randomized and directed stimulus for gpio_ctrl, checked by a
// scoreboard fed from a pin-history reference model.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int W = GPIO_WIDTH_DEFAULT;
    localparam int S = GPIO_SYNC_STAGES_DEFAULT;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         memEn = 1'b0;
    logic         memWe = 1'b0;
    logic [4:0]   addr = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic         irq;
    wire  [W-1:0] gpio;

    logic [W-1:0] tbEn = '0;
    logic [W-1:0] tbVal = '0;
    logic [W-1:0] nxtPinEn = '1;
    logic [W-1:0] nxtPinVal = '0;

    // Reference model: architectural registers plus a history of sampled pin levels.
    logic [W-1:0] mOut, mDir, mEn, mStat, mRd;
    bit           mIrq;
    logic [W-1:0] pinHist[$];

    typedef struct {
        string        tag;
        logic [W-1:0] expRd;
        bit           expIrq;
        logic [W-1:0] expGpio;
    } exp_t;

    exp_t  expQ[$];
    int    compared = 0;
    int    mismatched = 0;
    string curTag = "";

    gpio_ctrl #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_en (memEn),
        .mem_we (memWe),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .gpio   (gpio),
        .irq    (irq)
    );

    // External pin drivers; only pins the DUT is not driving are ever enabled.
    for (genvar i = 0; i < W; i++) begin : g_ext
        assign gpio[i] = tbEn[i] ? tbVal[i] : 1'bz;
    end

    always #5 clk = ~clk;

    function automatic void modelReset();
        mOut = '0; mDir = '0; mEn = '0; mStat = '0; mRd = '0; mIrq = 1'b0;
        pinHist.delete();
        for (int i = 0; i < S + 2; i++) pinHist.push_back('0);
    endfunction

    // Advances the model across the coming clock edge and queues what the DUT should show after it.
    function automatic void modelStep();
        logic [W-1:0] pinNow, inVal, prevVal, rise, rdVal;
        bit           irqNext;
        int           n;
        exp_t         e;
        pinNow = (mDir & mOut) | (~mDir & tbEn & tbVal);
        if (!rst) begin
            modelReset();
        end else begin
            n       = pinHist.size();
            inVal   = pinHist[n-S];
            prevVal = pinHist[n-S-1];
            pinHist.push_back(pinNow);
            void'(pinHist.pop_front());
            rise    = inVal & ~prevVal;
            irqNext = |(mStat & mEn);
            if (memEn && !memWe) begin
                case (addr[4:2])
                    3'd0:    rdVal = mOut;
                    3'd1:    rdVal = mDir;
                    3'd2:    rdVal = inVal;
                    3'd3:    rdVal = mEn;
                    3'd4:    rdVal = mStat;
                    default: rdVal = '0;
                endcase
                mRd = rdVal;
            end
            if (memEn && memWe) begin
                case (addr[4:2])
                    3'd0: mOut = wdata;
                    3'd1: mDir = wdata;
`ifdef GPIO_IRQ_EN
                    3'd3: mEn = wdata;
                    3'd4: mStat = mStat & ~wdata;
`endif
                    default: ;
                endcase
            end
`ifdef GPIO_IRQ_EN
            mStat = mStat | rise;
            mIrq  = irqNext;
`else
            mIrq  = 1'b0;
`endif
        end
        e.tag     = curTag;
        e.expRd   = mRd;
        e.expIrq  = mIrq;
        e.expGpio = (mDir & mOut) | (~mDir & tbEn & tbVal);
        expQ.push_back(e);
    endfunction

    task automatic applyStimulus(input bit r, input bit en, input bit we,
                                 input logic [4:0] a, input logic [W-1:0] wd, input string tag);
        logic [W-1:0] mask;
        @(negedge clk);
        rst = r; memEn = en; memWe = we; addr = a; wdata = wd;
        mask = ~mDir;
        if (r && en && we && a[4:2] == 3'd1) mask = mask & ~wd;
        tbEn   = nxtPinEn & mask;
        tbVal  = nxtPinVal;
        curTag = tag;
        modelStep();
    endtask

    task automatic wr(input logic [4:0] a, input logic [W-1:0] d, input string tag);
        applyStimulus(1'b1, 1'b1, 1'b1, a, d, tag);
    endtask

    task automatic rd(input logic [4:0] a, input string tag);
        applyStimulus(1'b1, 1'b1, 1'b0, a, '0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'h0, '0, tag);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (rdata !== e.expRd) begin
            mismatched++;
            $display("[TB] FAIL rdata (%s): got %h expected %h", e.tag, rdata, e.expRd);
        end
        compared++;
        if (irq !== e.expIrq) begin
            mismatched++;
            $display("[TB] FAIL irq (%s): got %0b expected %0b", e.tag, irq, e.expIrq);
        end
        compared++;
        if (gpio !== e.expGpio) begin
            mismatched++;
            $display("[TB] FAIL gpio (%s): got %h expected %h", e.tag, gpio, e.expGpio);
        end
    endtask

    // Monitor: one queued expectation per clock edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h0, '0, "reset");
        applyStimulus(1'b0, 1'b1, 1'b1, OFF_OUT, '1, "write during reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h0, '0, "reset");
        idle(1, "first cycle after reset");
        rd(OFF_DIR, "read DIR after reset");
        rd(OFF_OUT, "read OUT after reset");

        wr(OFF_DIR, 32'h0000FFFF, "write DIR");
        wr(OFF_OUT, 32'hA5A5A5A5, "write OUT");
        rd(OFF_OUT, "read OUT");
        idle(1, "hold OUT readback");

        nxtPinVal[31:16] = 16'h1234;
        idle(S, "pins change");
        rd(OFF_IN, "read IN");
        idle(1, "hold IN readback");

        wr(OFF_IRQ_EN, 32'h00010000, "write IRQ_EN");
        wr(OFF_IRQ_STAT, '1, "clear IRQ_STAT");
        rd(OFF_IRQ_EN, "read IRQ_EN");
        nxtPinVal[16] = 1'b1;
        idle(S + 3, "edge on pin 16");
        rd(OFF_IRQ_STAT, "read IRQ_STAT after edge");
        wr(OFF_IRQ_STAT, 32'h00010000, "W1C bit 16");
        idle(3, "after W1C");

        nxtPinVal[16] = 1'b0;
        idle(S + 2, "pin 16 low");
        nxtPinVal[16] = 1'b1;
        idle(S, "pin 16 rising");
        rd(OFF_IRQ_STAT, "read IRQ_STAT on edge cycle");
        rd(OFF_IRQ_STAT, "read IRQ_STAT after edge cycle");
        idle(2, "irq set again");

        nxtPinVal[16] = 1'b0;
        idle(S + 2, "pin 16 low");
        nxtPinVal[16] = 1'b1;
        idle(S, "pin 16 rising");
        wr(OFF_IRQ_STAT, 32'h00010000, "W1C same cycle as edge");
        rd(OFF_IRQ_STAT, "read IRQ_STAT after collision");
        idle(3, "irq held after collision");

        rd(5'h18, "read 0x18");
        rd(5'h14, "read 0x14");
        rd(5'h1C, "read 0x1C");
        wr(5'h18, '1, "write 0x18");
        wr(OFF_IN, '1, "write IN");
        rd(OFF_IN, "read IN after write");
        rd(5'h03, "read OUT with low addr bits");
        applyStimulus(1'b0, 1'b1, 1'b1, OFF_OUT, 32'h12345678, "reset mid write");
        rd(OFF_OUT, "read OUT after aborted write");

        for (int i = 0; i < 400; i++) begin
            bit r, en, we;
            r  = ($urandom_range(0, 63) != 0);
            en = $urandom_range(0, 1);
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) nxtPinVal = $urandom;
            else nxtPinVal[$urandom_range(0, W-1)] = $urandom_range(0, 1);
            applyStimulus(r, en, we, 5'($urandom_range(0, 31)), $urandom, "random");
        end
        idle(2, "drain");

        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
